// File: rtl/tmr_unit_pkg.sv
// Shared timer definitions: control-word layout and FSM state encodings.
// These are the same field positions and state codes the register file
// uses for TCON and the TMR read path.
package tmr_unit_pkg;

    // Control word as seen in TCON (bit 0 is en, bits 31:16 are top).
    typedef struct packed {
        logic [15:0] top;   // compare value; 0 selects full-range wrap
        logic [7:0]  rsvd;
        logic [3:0]  ps;    // prescale exponent, tick every 2^ps clocks
        logic        ack;   // clear the sticky flag
        logic        clr;   // zero count/prescaler and go idle
        logic        ar;    // auto-reload on match
        logic        en;
    } tmr_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/tmr_unit_if.sv
// Timer register-file link: control word in, count/flag/state out.
interface tmr_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      tmr_ctrl;
    logic [CNT_W-1:0] tmr_cntr;
    logic             tmr_flag;
    logic [1:0]       tmr_state;

    // Register file side
    modport master (
        output tmr_ctrl,
        input  tmr_cntr, tmr_flag, tmr_state
    );

    // Timer side
    modport slave (
        input  tmr_ctrl,
        output tmr_cntr, tmr_flag, tmr_state
    );
endinterface

// File: rtl/tmr_prescaler.sv
// Prescaler: while run is held, pulses tick once every 2^ps clocks.
// The counter restarts from zero whenever the timer stops running, so the
// first tick after (re)entering RUN always comes a full period later.
// PS_W must be at least 15 to cover every ps value.
module tmr_prescaler #(
    parameter int PS_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       run,
    input  logic [3:0] ps,
    output logic       tick
);
    logic [PS_W-1:0] cnt;
    logic [PS_W-1:0] mask;

    assign mask = PS_W'((32'd1 << ps) - 32'd1);
    // >= rather than == so a mid-run drop of ps ticks at once instead of
    // walking the counter all the way round.
    assign tick = run && (cnt >= mask);

    // Divider counter; zeroed when idle, cleared, or on each tick
    always_ff @(posedge clk) begin
        if (rst || clear || !run)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + PS_W'(1);
    end
endmodule

// File: rtl/tmr_unit.sv
// Timer unit: up-counter with compare match, sticky flag, optional
// auto-reload, and a run/idle/done FSM driven by the TCON control word.
// Build option: define TMR_PRESCALE_EN to add the 2^PS prescaler; without
// it PS is ignored and the counter ticks on every clock in RUN.
module tmr_unit #(
    parameter int CNT_W = 16,
    parameter int PS_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    tmr_unit_if.slave  bus
);
    import tmr_unit_pkg::*;

    tmr_ctrl_t        c;
    tmr_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] match;
    logic             flag, flag_nx;
    logic             run;
    logic             tick;
    logic             unused_bits;

    assign c = bus.tmr_ctrl;

    // top = 0 means "match at all-ones" so the full range is usable
    assign match = (c.top == '0) ? '1 : CNT_W'(c.top);

    // Counting is only live on a clock that keeps us in RUN
    assign run = (state == ST_RUN) && c.en && !c.clr;

`ifdef TMR_PRESCALE_EN
    tmr_prescaler #(.PS_W(PS_W)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (c.clr),
        .run   (run),
        .ps    (c.ps),
        .tick  (tick)
    );
    assign unused_bits = ^c.rsvd;
`else
    assign tick        = run;
    assign unused_bits = ^{c.rsvd, c.ps, 1'(PS_W)};
`endif

    // State, count and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            flag  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            flag  <= flag_nx;
        end
    end

    // Next-state, count and flag update; clr beats every other control bit
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        flag_nx  = flag && !c.ack;
        if (c.clr) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (c.en)
                        state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (!c.en) begin
                        state_nx = ST_IDLE;
                    end else if (tick) begin
                        if (cnt == match) begin
                            // a match in the same clock as ack still sets
                            flag_nx = 1'b1;
                            if (c.ar)
                                cnt_nx = '0;
                            else
                                state_nx = ST_DONE;
                        end else begin
                            // top lowered below cnt: wrap through all-ones
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    if (!c.en)
                        state_nx = ST_IDLE;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign bus.tmr_cntr  = cnt;
    assign bus.tmr_flag  = flag;
    assign bus.tmr_state = state;
endmodule

// File: tb/tb_tmr_unit.sv
// Directed bench for tmr_unit: each step drives a control word, pushes the
// expected post-edge outputs to a scoreboard and pops/compares them after
// the edge. Covers both TMR_PRESCALE_EN builds.
module tb_tmr_unit;
    import tmr_unit_pkg::*;

    typedef struct packed {
        logic [15:0] cnt;
        logic        flag;
        logic [1:0]  st;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    tmr_unit_if #(.CNT_W(16)) bus();

    tmr_unit #(.CNT_W(16), .PS_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit en, input bit ar, input bit clr,
                                       input bit ack, input logic [3:0] ps,
                                       input logic [15:0] top);
        tmr_ctrl_t c;
        c     = '0;
        c.en  = en;
        c.ar  = ar;
        c.clr = clr;
        c.ack = ack;
        c.ps  = ps;
        c.top = top;
        return c;
    endfunction

    task automatic step(input string tag, input logic [31:0] ctrl,
                        input logic [15:0] ec, input logic ef, input logic [1:0] es);
        exp_t e;
        bus.tmr_ctrl = ctrl;
        sb.push_back('{cnt: ec, flag: ef, st: es});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".cnt"},   32'(bus.tmr_cntr),  32'(e.cnt));
        chk({tag, ".flag"},  32'(bus.tmr_flag),  32'(e.flag));
        chk({tag, ".state"}, 32'(bus.tmr_state), 32'(e.st));
    endtask

    initial begin
        logic [31:0] c;
        n_chk  = 0;
        n_fail = 0;
        rst          = 1'b1;
        bus.tmr_ctrl = '0;
        @(posedge clk);
        #1;
        // reset wins over en
        step("reset", mk(1, 0, 0, 0, 0, 16'd3), 16'd0, 1'b0, ST_IDLE);
        rst = 1'b0;

        // auto-reload, top=3: 0,1,2,3,0,... flag on the 3->0 edge
        c = mk(1, 1, 0, 0, 0, 16'd3);
        step("a_start", c, 16'd0, 1'b0, ST_RUN);
        for (int i = 1; i <= 6; i++)
            step("a_cnt", c, 16'(i % 4), (i >= 4), ST_RUN);
        c = mk(1, 1, 0, 1, 0, 16'd3);
        step("a_ack",       c, 16'd3, 1'b0, ST_RUN);
        step("a_ack_match", c, 16'd0, 1'b1, ST_RUN);
        step("a_ack_hold",  c, 16'd1, 1'b0, ST_RUN);
        step("a_clr", mk(1, 1, 1, 0, 0, 16'd3), 16'd0, 1'b0, ST_IDLE);

        // one-shot, top=2: stops in DONE, en drop keeps the count
        c = mk(1, 0, 0, 0, 0, 16'd2);
        step("b_start", c, 16'd0, 1'b0, ST_RUN);
        step("b_cnt",   c, 16'd1, 1'b0, ST_RUN);
        step("b_cnt",   c, 16'd2, 1'b0, ST_RUN);
        step("b_match", c, 16'd2, 1'b1, ST_DONE);
        step("b_hold",  c, 16'd2, 1'b1, ST_DONE);
        step("b_en_off", mk(0, 0, 0, 0, 0, 16'd2), 16'd2, 1'b1, ST_IDLE);
        step("b_clr",    mk(0, 0, 1, 1, 0, 16'd2), 16'd0, 1'b0, ST_IDLE);

        // pause/resume, then clr mid-count at 5 and restart from 0
        c = mk(1, 1, 0, 0, 0, 16'd10);
        step("c_start", c, 16'd0, 1'b0, ST_RUN);
        for (int i = 1; i <= 3; i++)
            step("c_cnt", c, 16'(i), 1'b0, ST_RUN);
        step("c_pause",  mk(0, 1, 0, 0, 0, 16'd10), 16'd3, 1'b0, ST_IDLE);
        step("c_resume", c, 16'd3, 1'b0, ST_RUN);
        step("c_cnt",    c, 16'd4, 1'b0, ST_RUN);
        step("c_cnt",    c, 16'd5, 1'b0, ST_RUN);
        step("c_clr",    mk(1, 1, 1, 0, 0, 16'd10), 16'd0, 1'b0, ST_IDLE);
        step("c_restart", c, 16'd0, 1'b0, ST_RUN);
        step("c_cnt",    c, 16'd1, 1'b0, ST_RUN);
        step("c_cnt",    c, 16'd2, 1'b0, ST_RUN);

        // top lowered below the count: no early match, keeps counting up
        c = mk(1, 1, 0, 0, 0, 16'd1);
        for (int i = 3; i <= 5; i++)
            step("d_no_early", c, 16'(i), 1'b0, ST_RUN);
        step("d_clr", mk(0, 0, 1, 0, 0, 16'd1), 16'd0, 1'b0, ST_IDLE);

        // ps=2, top=1, auto-reload
        c = mk(1, 1, 0, 0, 4'd2, 16'd1);
        step("e_start", c, 16'd0, 1'b0, ST_RUN);
`ifdef TMR_PRESCALE_EN
        for (int k = 1; k <= 8; k++)
            step("e_ps", c, (k >= 4 && k < 8) ? 16'd1 : 16'd0, (k == 8), ST_RUN);
`else
        for (int k = 1; k <= 4; k++)
            step("e_ps", c, 16'(k % 2), (k >= 2), ST_RUN);
`endif
        step("e_clr", mk(0, 0, 1, 1, 0, 16'd1), 16'd0, 1'b0, ST_IDLE);

        // set the flag, run up to 0x1234, then reset mid-run
        c = mk(1, 1, 0, 0, 0, 16'd1);
        step("f_start", c, 16'd0, 1'b0, ST_RUN);
        step("f_cnt",   c, 16'd1, 1'b0, ST_RUN);
        step("f_match", c, 16'd0, 1'b1, ST_RUN);
        c = mk(1, 1, 0, 0, 0, 16'h2000);
        for (int i = 1; i <= 16'h1234; i++)
            step("f_run", c, 16'(i), 1'b1, ST_RUN);
        rst = 1'b1;
        step("f_rst", c, 16'd0, 1'b0, ST_IDLE);
        rst = 1'b0;
        step("f_after_rst", c, 16'd0, 1'b0, ST_RUN);
        step("f_cnt",       c, 16'd1, 1'b0, ST_RUN);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
